// File: rtl/spi_adc_sampler.sv
// SPI master for a multi-channel serial ADC (CPOL=0, MSB-first) with round-robin
// channel sequencing, single-shot/continuous framing and a valid/ready result port.
module spi_adc_sampler #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned LEAD_BITS  = 4,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned ADDR_POS   = 2,
  parameter int unsigned HALF       = 1,
  parameter int unsigned QUIET      = 2,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clr_ovr,
  input  logic              SDO,
  output logic              CS,
  output logic              SCK,
  output logic              MOSI,
  output logic [DATA_W-1:0] sample,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned KW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned QW = (QUIET > 1) ? $clog2(QUIET) : 1;
  localparam logic [KW-1:0] LAST_BIT   = KW'(FRAME_BITS - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t            state, state_n;
  logic [KW-1:0]     bit_cnt;
  logic [HW-1:0]     half_cnt;
  logic [QW-1:0]     quiet_cnt;
  logic [CH_W-1:0]   ptr, prev_addr;
  logic [CH_W-1:0]   next_ch, cand;
  logic              found;
  logic [DATA_W-1:0] shreg;
  logic              frame_go, sck_rise, sck_fall, frame_end;

  function automatic logic addr_bit(input int unsigned k, input logic [CH_W-1:0] a);
    logic [CH_W-1:0] sh;
    sh = '0;
    if (k >= ADDR_POS && k < ADDR_POS + CH_W) sh = a << (k - ADDR_POS);
    return sh[CH_W-1];
  endfunction

  // First enabled channel strictly after the last one sent, wrapping; empty mask -> 0.
  always_comb begin
    next_ch = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((32'(ptr) + i) % NUM_CH);
      if (!found && ch_mask[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    frame_go  = 1'b0;
    sck_rise  = 1'b0;
    sck_fall  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (start || cont) begin
          frame_go = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (half_cnt == HALF_LAST) begin
          if (!SCK) sck_rise = 1'b1;
          else begin
            sck_fall = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              frame_end = 1'b1;
              state_n   = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (quiet_cnt == QUIET_LAST) begin
          if (cont) begin
            frame_go = 1'b1;
            state_n  = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CS           <= 1'b1;
      SCK          <= 1'b0;
      MOSI         <= 1'b0;
      bit_cnt      <= '0;
      half_cnt     <= '0;
      quiet_cnt    <= '0;
      ptr          <= '0;
      prev_addr    <= '0;
      shreg        <= '0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (frame_go) begin
        CS        <= 1'b0;
        SCK       <= 1'b0;
        MOSI      <= addr_bit(0, next_ch);
        bit_cnt   <= '0;
        half_cnt  <= '0;
        quiet_cnt <= '0;
        ptr       <= next_ch;
      end else if (state == SHIFT) begin
        half_cnt <= (half_cnt == HALF_LAST) ? '0 : half_cnt + 1'b1;
        if (sck_rise) begin
          SCK <= 1'b1;
          if (32'(bit_cnt) >= LEAD_BITS && 32'(bit_cnt) < LEAD_BITS + DATA_W)
            shreg <= {shreg[DATA_W-2:0], SDO};
        end
        if (sck_fall) begin
          SCK <= 1'b0;
          if (frame_end) begin
            CS        <= 1'b1;
            MOSI      <= 1'b0;
            quiet_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            MOSI    <= addr_bit(32'(bit_cnt) + 1, ptr);
          end
        end
      end else if (state == HOLD) begin
        quiet_cnt <= quiet_cnt + 1'b1;
      end

      // ADC answers one frame late, so the reported channel is the previous address.
      if (frame_end) begin
        sample       <= shreg;
        sample_ch    <= prev_addr;
        prev_addr    <= ptr;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (frame_end && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clr_ovr)                               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Scoreboard bench for spi_adc_sampler: a serial ADC model drives SDO, and a monitor
// compares every loaded result and every received MOSI frame against queued expectations.
module tb_spi_adc_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, cont = 1'b0, clr_ovr = 1'b0, sdo = 1'b0, sample_ready = 1'b0;
  logic [7:0] ch_mask = '0;
  logic       cs, sck, mosi, sample_valid, overrun, busy;
  logic [11:0] sample;
  logic [2:0]  sample_ch;

  logic       start2 = 1'b0, sdo2 = 1'b0;
  logic       cs2, sck2, mosi2, valid2, ovr2, busy2;
  logic [9:0] sample2;
  logic [2:0] ch2;

  spi_adc_sampler dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_mask(ch_mask),
    .clr_ovr(clr_ovr), .SDO(sdo), .CS(cs), .SCK(sck), .MOSI(mosi),
    .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .busy(busy)
  );

  spi_adc_sampler #(.DATA_W(10), .LEAD_BITS(6), .HALF(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cont(1'b0), .ch_mask(8'h00),
    .clr_ovr(1'b0), .SDO(sdo2), .CS(cs2), .SCK(sck2), .MOSI(mosi2),
    .sample(sample2), .sample_ch(ch2), .sample_valid(valid2),
    .sample_ready(1'b0), .overrun(ovr2), .busy(busy2)
  );

  int passed = 0, total = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: got timeout expected DUT event", name);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [11:0] adc_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return 12'hA5C;
      3'd1:    return 12'h123;
      3'd2:    return 12'h456;
      3'd5:    return 12'h789;
      default: return 12'h3C3;
    endcase
  endfunction

  // Non-data frame bits are driven high so a capture window error shows up.
  function automatic logic frame_bit(input logic [11:0] w, input int k, input int lead, input int dw);
    logic [11:0] t;
    if (k >= lead && k < lead + dw) begin
      t = w >> (dw - 1 - (k - lead));
      return t[0];
    end
    return 1'b1;
  endfunction

  typedef struct packed { logic [11:0] val; logic [2:0] ch; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] mosi_q[$];

  task automatic expect_frame(input logic [2:0] reported, input logic [2:0] sent);
    exp_q.push_back('{val: adc_val(reported), ch: reported});
    mosi_q.push_back(16'(sent) << 11);
  endtask

  // ADC model for dut: answers with the conversion of the address received last frame.
  logic        m_cs_q = 1'b1, m_sck_q = 1'b0;
  int          mk = 0;
  logic [2:0]  mprev = '0;
  logic [11:0] mword = '0;
  logic [15:0] mmosi = '0;
  always @(negedge clk) begin
    if (rst) begin
      mprev = '0; sdo = 1'b0; mk = 0;
    end else begin
      if (m_cs_q && !cs) begin
        mk = 0; mword = adc_val(mprev); mmosi = '0;
        sdo = frame_bit(mword, 0, 4, 12);
      end else if (!cs && m_sck_q && !sck) begin
        mk++;
        sdo = frame_bit(mword, mk, 4, 12);
      end
      if (!cs && !m_sck_q && sck) mmosi = {mmosi[14:0], mosi};
      if (!m_cs_q && cs) begin
        mprev = mmosi[13:11];
        if (mosi_q.size() == 0) timeout("mosi_unexpected_frame");
        else check("mosi_word", mmosi, mosi_q.pop_front());
      end
    end
    m_cs_q  = cs;
    m_sck_q = sck;
  end

  logic m2_cs_q = 1'b1, m2_sck_q = 1'b0;
  int   m2k = 0;
  always @(negedge clk) begin
    if (rst) begin
      sdo2 = 1'b0; m2k = 0;
    end else if (m2_cs_q && !cs2) begin
      m2k = 0; sdo2 = frame_bit(12'h2AB, 0, 6, 10);
    end else if (!cs2 && m2_sck_q && !sck2) begin
      m2k++; sdo2 = frame_bit(12'h2AB, m2k, 6, 10);
    end
    m2_cs_q  = cs2;
    m2_sck_q = sck2;
  end

  // Result monitor: a CS rise outside reset is a result load.
  logic cs_q = 1'b1;
  int   falls = 0, rises = 0, fall_cyc = 0, rise_cyc = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (cs_q && !cs) begin falls++; fall_cyc = cyc; end
      if (!cs_q && cs) begin
        rises++; rise_cyc = cyc;
        if (exp_q.size() == 0) timeout("result_unexpected");
        else begin
          e = exp_q.pop_front();
          check("sample", sample, e.val);
          check("sample_ch", sample_ch, e.ch);
          check("sample_valid_on_load", sample_valid, 1);
        end
      end
    end
    cs_q = cs;
  end

  task automatic wait_falls(input int target);
    int n = 0;
    while (falls < target && n < 300) begin step(); n++; end
    if (falls < target) timeout("wait_cs_fall");
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises < target && n < 300) begin step(); n++; end
    if (rises < target) timeout("wait_cs_rise");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    if (busy) timeout("wait_idle");
  endtask

  initial begin
    int n, pulses, t, base, base_r, hi, lo, r;
    logic ps;

    step(); step();
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_ovr_busy", {overrun, busy}, 0);
    rst = 1'b0;
    step();

    // Single shot on channel 0, ready held low.
    expect_frame(3'd0, 3'd0);
    n = 0; pulses = 0; ps = 1'b0;
    start = 1'b1;
    do begin
      step(); n++;
      if (n == 1) start = 1'b0;
      if (sck && !ps) pulses++;
      ps = sck;
    end while (!sample_valid && n < 100);
    check("t1_latency", n, 33);
    check("t1_sck_pulses", pulses, 16);
    wait_idle();
    check("t1_valid_held", sample_valid, 1);
    sample_ready = 1'b1; step(); sample_ready = 1'b0;
    check("t1_valid_drop", sample_valid, 0);

    // Continuous round robin over channels 1, 2, 5.
    sample_ready = 1'b1;
    ch_mask = 8'b0010_0110;
    expect_frame(3'd0, 3'd1);
    expect_frame(3'd1, 3'd2);
    expect_frame(3'd2, 3'd5);
    expect_frame(3'd5, 3'd1);
    base = falls;
    cont = 1'b1;
    wait_falls(base + 1);
    t = fall_cyc;
    for (int i = 2; i <= 4; i++) begin
      wait_falls(base + i);
      check("t2_period", fall_cyc - t, 34);
      t = fall_cyc;
    end
    cont = 1'b0;
    wait_idle();
    check("t2_all_results", exp_q.size(), 0);
    check("t2_ovr", overrun, 0);

    // Overrun with ready low; clear coincident with a set must lose.
    sample_ready = 1'b0;
    ch_mask = 8'b0000_0110;
    expect_frame(3'd1, 3'd2);
    expect_frame(3'd2, 3'd1);
    expect_frame(3'd1, 3'd2);
    base = falls;
    cont = 1'b1;
    wait_falls(base + 2);
    check("t3_ovr_first", overrun, 0);
    check("t3_valid_first", sample_valid, 1);
    wait_falls(base + 3);
    check("t3_ovr_set", overrun, 1);
    cont = 1'b0;
    repeat (31) step();
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    check("t3_load_edge", cs, 1);
    check("t3_set_wins", overrun, 1);
    wait_idle();
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    check("t3_ovr_clear", overrun, 0);

    // Ready on the exact load edge: clean handoff.
    ch_mask = 8'h00;
    expect_frame(3'd2, 3'd0);
    base = falls;
    start = 1'b1; step(); start = 1'b0;
    wait_falls(base + 1);
    repeat (31) step();
    sample_ready = 1'b1; step(); sample_ready = 1'b0;
    check("t4_valid", sample_valid, 1);
    check("t4_ovr", overrun, 0);
    step();
    check("t4_valid_hold", sample_valid, 1);
    wait_idle();

    // Reset at bit 7 aborts the frame with no result.
    base = falls;
    start = 1'b1; step(); start = 1'b0;
    wait_falls(base + 1);
    repeat (14) step();
    rst = 1'b1;
    #1;
    check("t5_cs", cs, 1);
    check("t5_sck", sck, 0);
    check("t5_valid", sample_valid, 0);
    check("t5_busy", busy, 0);
    step(); step();
    rst = 1'b0;
    step();
    expect_frame(3'd0, 3'd0);
    base = falls; base_r = rises;
    start = 1'b1; step(); start = 1'b0;
    wait_falls(base + 1);
    wait_rises(base_r + 1);
    check("t5_frame_len", rise_cyc - fall_cyc, 32);
    wait_idle();

    // HALF=3, DATA_W=10, LEAD_BITS=6 instance.
    n = 0; hi = 0; lo = 0; r = 0; ps = 1'b0;
    start2 = 1'b1;
    do begin
      step(); n++;
      if (n == 1) start2 = 1'b0;
      if (!cs2) begin
        if (sck2) hi++; else lo++;
        if (sck2 && !ps) r++;
      end
      ps = sck2;
    end while (!valid2 && n < 400);
    check("h3_latency", n, 97);
    check("h3_sck_high", hi, 48);
    check("h3_sck_low", lo, 48);
    check("h3_pulses", r, 16);
    check("h3_sample", sample2, 10'h2AB);
    check("h3_ch", ch2, 0);

    check("end_result_queue", exp_q.size(), 0);
    check("end_mosi_queue", mosi_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_adc_sampler.md
# spi_adc_sampler

Parametrised SPI master that runs a multi-channel serial ADC (CPOL=0, MSB-first, channel address on MOSI) and returns each conversion through a valid/ready interface. It is the next-generation replacement for the fixed 12-bit single-channel ADC reader in the data-collection path. It adds:
- configurable width, frame length and SCK rate;
- round-robin channel sequencing;
- single-shot and continuous modes;
- output holding with overrun detection.

## Interface
- DATA_W, 12: conversion width in bits.
- FRAME_BITS, 16: SCK cycles per CS-low frame; LEAD_BITS + DATA_W <= FRAME_BITS.
- LEAD_BITS, 4: frame bits preceding the data MSB.
- NUM_CH, 8: ADC channels; CH_W = max(1, clog2(NUM_CH)).
- ADDR_POS, 2: frame bit index carrying the address MSB; ADDR_POS + CH_W <= FRAME_BITS.
- HALF, 1: SCK half-period in clk cycles, >= 1.
- QUIET, 2: CS-high clk cycles between frames, >= 1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-shot request; ignored while busy.
- cont  in  1  continuous mode; frames run back-to-back while high.
- ch_mask  in  NUM_CH  enabled channels; all-zero means channel 0 only.
- clr_ovr  in  1  clears overrun.
- SDO  in  1  ADC serial data (MISO).
- CS  out  1  active-low chip select.
- SCK  out  1  ADC serial clock, idle low.
- MOSI  out  1  channel address to ADC.
- sample  out  DATA_W  conversion result.
- sample_ch  out  CH_W  channel that sample belongs to.
- sample_valid  out  1  sample/sample_ch hold a result.
- sample_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky: an unaccepted result was overwritten.
- busy  out  1  high in every state other than IDLE.

## Operation
- Reset values: CS=1, SCK=0, MOSI=0, sample=0, sample_ch=0, sample_valid=0, overrun=0, busy=0. Address pointer and prev_addr are also 0. Reset mid-frame aborts immediately; no partial result is produced.
- States:
  - IDLE: leave to SHIFT on start or cont. The same edge drives CS=0 and latches the frame channel.
  - SHIFT: FRAME_BITS bits, bit index k = 0..FRAME_BITS-1. Each bit is SCK low for HALF cycles, then high for HALF cycles.
  - HOLD: CS=1 for QUIET cycles. Exit to SHIFT if cont is high, otherwise to IDLE.
- SDO capture: on the edge that drives SCK 0->1. Bits k in [LEAD_BITS, LEAD_BITS+DATA_W-1] shift into the result MSB-first; all other bits are discarded.
- MOSI update: on the edge that drives SCK 1->0, and at the frame-start edge for bit 0. MOSI carries address bit (CH_W-1-(k-ADDR_POS)) for k in [ADDR_POS, ADDR_POS+CH_W-1], and 0 otherwise.
- Channel select: the channel sent in a frame is the next enabled channel in ch_mask after the previous one, wrapping from NUM_CH-1 to 0. ch_mask is sampled at frame start.
- Pipelining: the ADC returns, in frame n, the conversion for the address sent in frame n-1. sample_ch is therefore loaded from prev_addr, and prev_addr then takes the current frame's address. The first frame after reset reports channel 0.
- Result load: at the edge ending the last SHIFT bit (SCK 1->0, CS 0->1), sample, sample_ch and sample_valid=1 are loaded.
- Handshake: sample_valid drops on a clk edge where sample_ready=1, unless a new result loads on that same edge, in which case sample_valid stays 1.
  - If a new result loads while sample_valid=1 and sample_ready=0, the new result overwrites the old one and overrun is set.
  - A load on the same edge as ready=1 is a clean handoff with no overrun.
- overrun clears on clr_ovr. If set and clear happen on the same edge, set wins.
- Mode changes:
  - cont falling mid-frame: the current frame completes, then the block goes to IDLE after HOLD.
  - start during busy: no effect.

## Timing
- Each frame holds CS low for exactly 2*HALF*FRAME_BITS clk cycles (32 at defaults).
- Frame period in continuous mode is 2*HALF*FRAME_BITS + QUIET cycles (34 at defaults).
- Latency from start sampled high to sample_valid is 1 + 2*HALF*FRAME_BITS cycles (33 at defaults).
- SCK frequency is clk/(2*HALF), i.e. clk/2 at defaults.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Single shot, defaults, ADC model returns 0xA5C on channel 0: pulse start, hold ready=0. Expect sample=0xA5C, sample_ch=0, sample_valid at cycle 33, and exactly 16 SCK pulses.
- Continuous, ch_mask=8'b0010_0110: MOSI address sequence 1,2,5,1,… and sample_ch sequence 0,1,2,5,…. Frames are 34 cycles apart.
- HALF=3, DATA_W=10, LEAD_BITS=6: SCK high and low phases are 3 cycles each. Model word 0x2AB gives sample=0x2AB.
- Overrun: cont=1 with ready held low for two frames gives the second sample value and overrun=1. clr_ovr coincident with a third overrun leaves overrun=1.
- Handshake edge: ready=1 on the exact load edge keeps valid high with the new data and leaves overrun=0.
- Reset mid-frame: assert rst at bit 7. CS=1, SCK=0 and sample_valid=0 immediately, with no result. The next start runs a clean 32-cycle frame.
